// File: rtl/hpdcache_mem_req_read_sched_pkg.sv
// Shared constants and helpers for the memory read-request scheduler.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Holds the default sizing used by the scheduler, its interface and the
// round-robin arbiter, plus the index-width helper that keeps a 1-bit index
// for the degenerate single-requester case.
package hpdcache_mem_req_read_sched_pkg;

    // Packed memory read request width coming from the shared cache config.
    localparam int unsigned HPDCACHE_MEM_REQ_WIDTH = 64;

    localparam int unsigned DEF_N               = 4;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;

    // Index width never collapses to zero bits, even for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hpdcache_mem_req_read_sched_if.sv
// Bundle of requester, memory-side and completion signals of the read scheduler.
// Latency: n/a (wires only).
// Backpressure: carried by req_ready_o and mem_req_ready_i.
//
// Signal names are written from the scheduler's point of view:
//   req_valid_i/req_ready_o/req_i          requester side (N lanes, packed)
//   mem_req_valid_o/mem_req_ready_i/...    memory read-request channel
//   rsp_done_i/rsp_done_src_i              completion pulses from response path
//   credit_err_o                           sticky credit underflow flag
// Modport slave is the scheduler, modport master is everything around it.
interface hpdcache_mem_req_read_sched_if
    import hpdcache_mem_req_read_sched_pkg::*;
#(
    parameter int unsigned N         = DEF_N,
    parameter int unsigned REQ_WIDTH = HPDCACHE_MEM_REQ_WIDTH,
    parameter int unsigned IDX_W     = idx_width(N)
);
    logic [N-1:0]           req_valid_i;
    logic [N-1:0]           req_ready_o;
    logic [N*REQ_WIDTH-1:0] req_i;

    logic                   mem_req_valid_o;
    logic                   mem_req_ready_i;
    logic [REQ_WIDTH-1:0]   mem_req_o;
    logic [IDX_W-1:0]       mem_req_src_o;

    logic                   rsp_done_i;
    logic [IDX_W-1:0]       rsp_done_src_i;
    logic                   credit_err_o;

    modport slave (
        input  req_valid_i, req_i, mem_req_ready_i, rsp_done_i, rsp_done_src_i,
        output req_ready_o, mem_req_valid_o, mem_req_o, mem_req_src_o, credit_err_o
    );

    modport master (
        output req_valid_i, req_i, mem_req_ready_i, rsp_done_i, rsp_done_src_i,
        input  req_ready_o, mem_req_valid_o, mem_req_o, mem_req_src_o, credit_err_o
    );

endinterface

// File: rtl/hpdcache_mem_req_read_sched_rrarb.sv
// Generic N-way round-robin arbiter with a registered search pointer.
// Latency: grant is combinational from req_i and the pointer.
// Backpressure: pointer only advances when en_i is high (grant was taken).
//
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   req_i          per-requester request
//   en_i           grant consumed this cycle, move pointer past the winner
//   gnt_o          one-hot grant (all zero when nothing is requested)
module hpdcache_rrarb
    import hpdcache_mem_req_read_sched_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               cand;
    int               win;

    // Scan N positions starting at the pointer; the first requester found wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        cand  = 0;
        win   = 0;
        for (int off = 0; off < int'(N); off++) begin
            cand = (int'(ptr_q) + off) % int'(N);
            if (!found && req_i[cand]) begin
                found      = 1'b1;
                win        = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

    // Next search starts just after the winner, so it becomes lowest priority.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i && found) begin
            ptr_d = IDX_W'((win + 1) % int'(N));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hpdcache_mem_req_read_sched.sv
// Round-robin read-request scheduler with per-requester outstanding-read credits.
// Latency: accept in cycle t, request visible on the memory channel in t+1.
// Backpressure: a requester is accepted only when the one-entry stage is empty
//               or draining this cycle and that requester still has credit.
//
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   bus (slave)    requester lanes, memory read-request channel, completion
//                  pulses and the sticky credit error flag
module hpdcache_mem_req_read_sched
    import hpdcache_mem_req_read_sched_pkg::*;
#(
    parameter int unsigned N               = DEF_N,
    parameter int unsigned REQ_WIDTH       = HPDCACHE_MEM_REQ_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    hpdcache_mem_req_read_sched_if.slave  bus
);

    localparam int unsigned IDX_W = idx_width(N);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0]     cnt_q [N];
    logic [CNT_W-1:0]     cnt_d [N];
    logic [N-1:0]         eligible;
    logic [N-1:0]         gnt;
    logic [N-1:0]         cnt_nz;
    logic [N-1:0]         dec_hit;
    logic                 can_load;
    logic                 accept;
    logic [REQ_WIDTH-1:0] sel_req;
    logic [IDX_W-1:0]     sel_src;

    logic                 stage_vld_q;
    logic [REQ_WIDTH-1:0] stage_dat_q;
    logic [IDX_W-1:0]     stage_src_q;
    logic                 credit_err_q;
    logic                 err_set;

    always_comb begin
        eligible = '0;
        cnt_nz   = '0;
        dec_hit  = '0;
        for (int i = 0; i < int'(N); i++) begin
            eligible[i] = bus.req_valid_i[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
            cnt_nz[i]   = (cnt_q[i] != '0);
            // An out-of-range source matches no lane, so it is ignored here
            // and shows up as a credit error below.
            dec_hit[i]  = bus.rsp_done_i && (bus.rsp_done_src_i == IDX_W'(i));
        end
    end

    hpdcache_rrarb #(
        .N     (N),
        .IDX_W (IDX_W)
    ) i_rrarb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (eligible),
        .en_i   (accept),
        .gnt_o  (gnt)
    );

    assign can_load        = !stage_vld_q || bus.mem_req_ready_i;
    assign bus.req_ready_o = gnt & {N{can_load}};
    assign accept          = |bus.req_ready_o;

    always_comb begin
        sel_req = '0;
        sel_src = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt[i]) begin
                sel_req = bus.req_i[i*REQ_WIDTH +: REQ_WIDTH];
                sel_src = IDX_W'(i);
            end
        end
    end

    // Credit is taken when the request enters the stage, so a request parked
    // in the stage already counts as outstanding. A completion for a lane with
    // no outstanding reads leaves the counter alone.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            cnt_d[i] = cnt_q[i];
            if ((accept && gnt[i]) && !(dec_hit[i] && cnt_nz[i])) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!(accept && gnt[i]) && (dec_hit[i] && cnt_nz[i])) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    assign err_set = bus.rsp_done_i && !(|(dec_hit & cnt_nz));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= '0;
            end
            stage_vld_q  <= 1'b0;
            stage_dat_q  <= '0;
            stage_src_q  <= '0;
            credit_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (accept) begin
                stage_vld_q <= 1'b1;
                stage_dat_q <= sel_req;
                stage_src_q <= sel_src;
            end else if (bus.mem_req_ready_i) begin
                stage_vld_q <= 1'b0;
            end
            if (err_set) begin
                credit_err_q <= 1'b1;
            end
        end
    end

    assign bus.mem_req_valid_o = stage_vld_q;
    assign bus.mem_req_o       = stage_dat_q;
    assign bus.mem_req_src_o   = stage_src_q;
    assign bus.credit_err_o    = credit_err_q;

endmodule
